// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg
//   Shared definitions for the round-robin mux arbiter family:
//   FSM state encoding and the width/limit of the per-requester
//   grant counters (used when MUX_RR_ARBITER_CNT_EN is defined).
package mux_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int               CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick
//   Purely combinational round-robin search. Finds the first set bit of
//   req starting at position ptr and wrapping from N-1 back to 0.
// Ports:
//   req   [N]   request vector
//   ptr   [SW]  highest-priority position (must be < N)
//   found [1]   at least one request bit is set
//   idx   [SW]  index of the selected request (0 when found is low)
module rr_pick #(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          found,
  output logic [SW-1:0] idx
);

  logic [SW-1:0] cand;

  // Scan from the farthest offset down to offset 0 so the candidate
  // closest to ptr is the last one written and therefore wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = SW'((int'(ptr) + i) % N);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter that shares one N:1 data mux between N
//   valid/ready requesters. In IDLE it grants one requester (combinational
//   req_ready), captures its word into a single-entry output register and
//   moves to HOLD; HOLD presents the word downstream until out_ready.
//   Throughput is at most one word every two cycles (no bypass).
// Optional feature:
//   `define MUX_RR_ARBITER_CNT_EN adds grant_cnt, one saturating 16-bit
//   grant counter per requester.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [N]    per-requester valid
//   req_data   [N*W]  requester i data at [i*W +: W]
//   req_ready  [N]    per-requester ready, one-hot or zero
//   out_valid         output register holds a word
//   out_data   [W]    captured word
//   out_ready         downstream accepts
//   grant_sel  [SW]   mux select of the current or last grant
//   busy              high while in HOLD
//   grant_cnt  [N*16] per-requester grant counters (optional)
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  input  logic           out_ready,
  output logic [SW-1:0]  grant_sel,
  output logic           busy
`ifdef MUX_RR_ARBITER_CNT_EN
  ,
  output logic [N*CNT_W-1:0] grant_cnt
`endif
);

  state_t        state, state_nxt;
  logic [SW-1:0] rr_ptr;
  logic          found;
  logic [SW-1:0] pick_idx;
  logic          grant;

  rr_pick #(.N(N)) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (found),
    .idx   (pick_idx)
  );

  assign grant = (state == ST_IDLE) && found;

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (found)     state_nxt = ST_HOLD;
      ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // ---- output logic ----
  // req_ready is gated by rst_n so it reads zero while reset is held,
  // even though requests may already be present.
  always_comb begin
    req_ready = '0;
    if (grant && rst_n) req_ready[pick_idx] = 1'b1;
    out_valid = (state == ST_HOLD);
    busy      = (state == ST_HOLD);
  end

  // ---- capture register and round-robin pointer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      grant_sel <= '0;
      rr_ptr    <= '0;
    end else if (grant) begin
      out_data  <= req_data[int'(pick_idx)*W +: W];
      grant_sel <= pick_idx;
      rr_ptr    <= (pick_idx == SW'(N - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

`ifdef MUX_RR_ARBITER_CNT_EN
  logic [CNT_W-1:0] cnt [N];

  // ---- per-requester saturating grant counters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else if (grant) begin
      for (int i = 0; i < N; i++) begin
        if (pick_idx == SW'(i) && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
//   Directed self-checking bench for mux_rr_arbiter (N=4, W=8).
//   Define MUX_RR_ARBITER_CNT_EN to also exercise the grant counters.
module tb_mux_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = $clog2(N);

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [SW-1:0]  grant_sel;
  logic           busy;
`ifdef MUX_RR_ARBITER_CNT_EN
  logic [N*16-1:0] grant_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mux_rr_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_sel (grant_sel),
    .busy      (busy)
`ifdef MUX_RR_ARBITER_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_g;

    // Reset with random inputs
    rst_n     = 1'b0;
    req_valid = 4'($urandom);
    req_data  = 32'($urandom);
    out_ready = 1'($urandom);
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_grant_sel", 32'(grant_sel), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    req_valid = '0;
    out_ready = 1'b1;
    req_data  = {8'h43, 8'hA5, 8'h21, 8'h10};
    #1 rst_n = 1'b1;
    tick();

    // Single requester on lane 2
    req_valid = 4'b0100;
    #1;
    chk("single_req_ready", 32'(req_ready), 32'b0100);
    chk("single_busy_idle", 32'(busy),      32'd0);
    tick();
    req_valid = '0;
    #1;
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_data",  32'(out_data),  32'hA5);
    chk("single_grant_sel", 32'(grant_sel), 32'd2);
    chk("single_ready_hold", 32'(req_ready), 32'd0);
    chk("single_busy_hold", 32'(busy),      32'd1);
    tick();
    chk("single_drain_valid", 32'(out_valid), 32'd0);
    chk("single_sel_kept",    32'(grant_sel), 32'd2);

    // Pointer back to 0, then all four requesting
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'(k % 4);
      #1;
      chk("all_req_ready", 32'(req_ready), 32'(1) << exp_g);
      tick();
      chk("all_grant_sel", 32'(grant_sel), 32'(exp_g));
      chk("all_out_data",  32'(out_data),  32'h10 + 32'h11 * 32'(exp_g));
      tick();
      chk("all_idle_gap",  32'(out_valid), 32'd0);
    end

    // Backpressure: pointer is at 1, lane 1 granted and held
    out_ready = 1'b0;
    #1;
    chk("bp_req_ready", 32'(req_ready), 32'b0010);
    tick();
    req_data[1*W +: W] = 8'hEE;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data",  32'(out_data),  32'h21);
      chk("bp_busy",      32'(busy),      32'd1);
      chk("bp_req_ready_hold", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release", 32'(out_valid), 32'd0);

    // Wrap: pointer at 2, only lane 3 requests, then lanes 3 and 0
    req_valid = 4'b1000;
    tick();
    chk("wrap_sel3", 32'(grant_sel), 32'd3);
    req_valid = 4'b1001;
    tick();
    #1;
    chk("wrap_req_ready", 32'(req_ready), 32'b0001);
    tick();
    chk("wrap_sel0",  32'(grant_sel), 32'd0);
    chk("wrap_data0", 32'(out_data),  32'h10);
    req_valid = '0;
    tick();

    // Three grants to lane 1, then reset in the middle of a HOLD
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      tick();
    end
`ifdef MUX_RR_ARBITER_CNT_EN
    chk("cnt_lane1", 32'(grant_cnt[1*16 +: 16]), 32'd3);
    chk("cnt_lane0", 32'(grant_cnt[0*16 +: 16]), 32'd0);
`endif
    out_ready = 1'b0;
    tick();
    chk("mid_hold_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy",      32'(busy),      32'd0);
    chk("mid_rst_grant_sel", 32'(grant_sel), 32'd0);
    chk("mid_rst_out_data",  32'(out_data),  32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
`ifdef MUX_RR_ARBITER_CNT_EN
    chk("mid_rst_cnt", grant_cnt[31:0] | grant_cnt[63:32], 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
